// File: rtl/priv_pkg.sv
// rtl/priv_pkg.sv - privilege controller states, fault codes and offset helper
package priv_pkg;

    typedef enum logic [1:0] {
        ST_KERNEL = 2'd0,
        ST_USER   = 2'd1,
        ST_FAULT  = 2'd2
    } priv_state_e;

    localparam logic [2:0] FC_NONE = 3'd0;
    localparam logic [2:0] FC_JUMP = 3'd1;
    localparam logic [2:0] FC_DMEM = 3'd2;
    localparam logic [2:0] FC_RF_W = 3'd3;
    localparam logic [2:0] FC_RF_A = 3'd4;
    localparam logic [2:0] FC_RF_B = 3'd5;

    // First user-space address; the caller truncates to its address width.
    function automatic logic [31:0] ring1_base(input logic [31:0] ring0_last);
        return ring0_last + 32'd1;
    endfunction

endpackage

// File: rtl/priv_checker.sv
// rtl/priv_checker.sv - combinational ring-0 range checks with priority encoding
module priv_checker
    import priv_pkg::*;
#(
    parameter int unsigned           ADDR_W         = 16,
    parameter int unsigned           SEL_W          = 5,
    parameter logic [ADDR_W-1:0]     RING0_LAST     = 'h7FFF,
    parameter logic [ADDR_W-1:0]     RING0_ENTRY    = '0,
    parameter logic [ADDR_W-1:0]     RING0_MEM_LAST = '0,
    parameter logic [SEL_W-1:0]      RING0_REG_LAST = '0
) (
    input  logic              check_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              dmem_access,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [SEL_W-1:0]  rf_a_sel,
    input  logic [SEL_W-1:0]  rf_b_sel,
    input  logic              rf_we,
    input  logic [SEL_W-1:0]  rf_wsel,
    output logic              violation,
    output logic [2:0]        code,
    output logic [ADDR_W-1:0] addr
);

    always_comb begin
        code = FC_NONE;
        addr = '0;
        if (check_en) begin
            if (jump && (jump_target <= RING0_LAST) && (jump_target != RING0_ENTRY)) begin
                code = FC_JUMP;
                addr = jump_target;
            end else if (dmem_access && (dmem_addr <= RING0_MEM_LAST)) begin
                code = FC_DMEM;
                addr = dmem_addr;
            end else if (rf_we && (rf_wsel <= RING0_REG_LAST)) begin
                code = FC_RF_W;
                addr = pc;
            end else if (rf_a_sel <= RING0_REG_LAST) begin
                code = FC_RF_A;
                addr = pc;
            end else if (rf_b_sel <= RING0_REG_LAST) begin
                code = FC_RF_B;
                addr = pc;
            end
        end
    end

    assign violation = (code != FC_NONE);

endmodule

// File: rtl/privilege_controller.sv
// rtl/privilege_controller.sv - ring-0/ring-1 mode FSM, fault record, offsets and run gate
module privilege_controller
    import priv_pkg::*;
#(
    parameter int unsigned           ADDR_W         = 16,
    parameter int unsigned           SEL_W          = 5,
    parameter logic [ADDR_W-1:0]     RING0_LAST     = 'h7FFF,
    parameter logic [ADDR_W-1:0]     RING0_ENTRY    = '0,
    parameter logic [ADDR_W-1:0]     RING0_MEM_LAST = '0,
    parameter logic [SEL_W-1:0]      RING0_REG_LAST = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_in,
    output logic              run_out,
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              dmem_access,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [SEL_W-1:0]  rf_a_sel,
    input  logic [SEL_W-1:0]  rf_b_sel,
    input  logic              rf_we,
    input  logic [SEL_W-1:0]  rf_wsel,
    input  logic              syscall_req,
    output logic [ADDR_W-1:0] prog_offset,
    output logic [ADDR_W-1:0] data_offset,
    output logic              privileged,
    output logic              fault,
    output logic [2:0]        fault_code,
    output logic [ADDR_W-1:0] fault_addr,
    input  logic              fault_clear,
    output logic [7:0]        viol_count
);

    localparam logic [ADDR_W-1:0] RING1_BASE = ADDR_W'(ring1_base(32'(RING0_LAST)));

    priv_state_e       state_q, state_d;
    logic [2:0]        code_q, code_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              viol_now;
    logic [2:0]        chk_code;
    logic [ADDR_W-1:0] chk_addr;

    priv_checker #(
        .ADDR_W        (ADDR_W),
        .SEL_W         (SEL_W),
        .RING0_LAST    (RING0_LAST),
        .RING0_ENTRY   (RING0_ENTRY),
        .RING0_MEM_LAST(RING0_MEM_LAST),
        .RING0_REG_LAST(RING0_REG_LAST)
    ) u_checker (
        .check_en   (state_q == ST_USER),
        .pc         (pc),
        .jump       (jump),
        .jump_target(jump_target),
        .dmem_access(dmem_access),
        .dmem_addr  (dmem_addr),
        .rf_a_sel   (rf_a_sel),
        .rf_b_sel   (rf_b_sel),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .violation  (viol_now),
        .code       (chk_code),
        .addr       (chk_addr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_KERNEL;
            code_q  <= FC_NONE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_KERNEL: begin
                if (jump && (jump_target > RING0_LAST)) state_d = ST_USER;
            end
            ST_USER: begin
                // A bad jump into ring 0 is a fault even if it also looks like a syscall.
                if (viol_now) begin
                    state_d = ST_FAULT;
                    code_d  = chk_code;
                    addr_d  = chk_addr;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end else if (jump && (jump_target == RING0_ENTRY)) begin
                    state_d = ST_KERNEL;
                end
            end
            ST_FAULT: begin
                if (fault_clear) state_d = ST_KERNEL;
            end
            default: state_d = ST_KERNEL;
        endcase
    end

    assign privileged  = (state_q == ST_KERNEL);
    assign fault       = (state_q == ST_FAULT);
    assign fault_code  = code_q;
    assign fault_addr  = addr_q;
    assign viol_count  = cnt_q;
    assign data_offset = (state_q == ST_USER) ? RING1_BASE : '0;
    assign prog_offset = ((state_q == ST_USER) && !syscall_req) ? RING1_BASE : '0;
    // Same-cycle gate so the violating instruction never commits.
    assign run_out     = run_in && (state_q != ST_FAULT) && !viol_now;

endmodule

// File: tb/tb_privilege_controller.sv
// tb/tb_privilege_controller.sv - randomized scoreboard bench for privilege_controller
module tb_privilege_controller;

    typedef struct {
        bit reset; bit run_in; int pc; bit jump; int jump_target;
        bit dmem_access; int dmem_addr; int rf_a_sel; int rf_b_sel;
        bit rf_we; int rf_wsel; bit syscall_req; bit fault_clear;
    } stim_t;

    typedef struct {
        bit run_out; int prog_offset; int data_offset; bit privileged;
        bit fault; int fault_code; int fault_addr; int viol_count;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, run_in, jump, dmem_access, rf_we, syscall_req, fault_clear;
    logic [15:0] pc, jump_target, dmem_addr;
    logic [4:0]  rf_a_sel, rf_b_sel, rf_wsel;
    logic        run_out, privileged, fault;
    logic [15:0] prog_offset, data_offset, fault_addr;
    logic [2:0]  fault_code;
    logic [7:0]  viol_count;

    privilege_controller dut (
        .clock(clock), .reset(reset), .run_in(run_in), .run_out(run_out), .pc(pc),
        .jump(jump), .jump_target(jump_target), .dmem_access(dmem_access),
        .dmem_addr(dmem_addr), .rf_a_sel(rf_a_sel), .rf_b_sel(rf_b_sel), .rf_we(rf_we),
        .rf_wsel(rf_wsel), .syscall_req(syscall_req), .prog_offset(prog_offset),
        .data_offset(data_offset), .privileged(privileged), .fault(fault),
        .fault_code(fault_code), .fault_addr(fault_addr), .fault_clear(fault_clear),
        .viol_count(viol_count)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 kernel, 1 user, 2 fault.
    int   m_mode, m_code, m_addr, m_count;
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{reset: 0, run_in: 1, pc: 16'h8100, jump: 0, jump_target: 0,
              dmem_access: 0, dmem_addr: 16'h9000, rf_a_sel: 1, rf_b_sel: 2,
              rf_we: 0, rf_wsel: 3, syscall_req: 0, fault_clear: 0};
        return s;
    endfunction

    // Violation code for the given inputs when in user mode, highest priority first.
    function automatic int user_violation(stim_t s, output int where);
        where = 0;
        if (s.jump && s.jump_target <= 32767 && s.jump_target != 0) begin where = s.jump_target; return 1; end
        if (s.dmem_access && s.dmem_addr == 0) begin where = 0; return 2; end
        where = s.pc;
        if (s.rf_we && s.rf_wsel == 0) return 3;
        if (s.rf_a_sel == 0) return 4;
        if (s.rf_b_sel == 0) return 5;
        return 0;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        int   vcode, vaddr;
        @(posedge clock);
        #1;
        reset = s.reset; run_in = s.run_in; pc = 16'(s.pc); jump = s.jump;
        jump_target = 16'(s.jump_target); dmem_access = s.dmem_access;
        dmem_addr = 16'(s.dmem_addr); rf_a_sel = 5'(s.rf_a_sel); rf_b_sel = 5'(s.rf_b_sel);
        rf_we = s.rf_we; rf_wsel = 5'(s.rf_wsel); syscall_req = s.syscall_req;
        fault_clear = s.fault_clear;
        vcode = (m_mode == 1) ? user_violation(s, vaddr) : 0;
        e.privileged  = (m_mode == 0);
        e.fault       = (m_mode == 2);
        e.fault_code  = m_code;
        e.fault_addr  = m_addr;
        e.viol_count  = m_count;
        e.data_offset = (m_mode == 1) ? 32768 : 0;
        e.prog_offset = (m_mode == 1 && !s.syscall_req) ? 32768 : 0;
        e.run_out     = s.run_in && m_mode != 2 && vcode == 0;
        exp_q.push_back(e);
        if (s.reset) begin
            m_mode = 0; m_code = 0; m_addr = 0; m_count = 0;
        end else if (m_mode == 0) begin
            if (s.jump && s.jump_target > 32767) m_mode = 1;
        end else if (m_mode == 1) begin
            if (vcode != 0) begin
                m_mode = 2; m_code = vcode; m_addr = vaddr;
                if (m_count < 255) m_count++;
            end else if (s.jump && s.jump_target == 0) m_mode = 0;
        end else if (s.fault_clear) m_mode = 0;
    endtask

    task automatic chk(input string name, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (vector %0d)", name, act, req, vectors);
        end
    endtask

    // Monitor: every vector the driver queued is compared mid-cycle.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("run_out",     int'(run_out),     int'(e.run_out));
                chk("prog_offset", int'(prog_offset), e.prog_offset);
                chk("data_offset", int'(data_offset), e.data_offset);
                chk("privileged",  int'(privileged),  int'(e.privileged));
                chk("fault",       int'(fault),       int'(e.fault));
                chk("fault_code",  int'(fault_code),  e.fault_code);
                chk("fault_addr",  int'(fault_addr),  e.fault_addr);
                chk("viol_count",  int'(viol_count),  e.viol_count);
            end
        end
    end

    initial begin
        stim_t s;
        int    r;
        s = idle();
        reset = 1; run_in = 0; pc = 0; jump = 0; jump_target = 0; dmem_access = 0;
        dmem_addr = 0; rf_a_sel = 1; rf_b_sel = 1; rf_we = 0; rf_wsel = 1;
        syscall_req = 0; fault_clear = 0;
        repeat (2) @(posedge clock);
        m_mode = 0; m_code = 0; m_addr = 0; m_count = 0;

        s = idle(); s.reset = 1; apply(s);
        apply(idle());
        s = idle(); s.jump = 1; s.jump_target = 16'h8000; apply(s);
        apply(idle());
        s = idle(); s.syscall_req = 1; s.jump = 1; s.jump_target = 0; apply(s);
        apply(idle());
        s = idle(); s.jump = 1; s.jump_target = 16'h8000; apply(s);
        s = idle(); s.jump = 1; s.jump_target = 16'h0010; apply(s);
        apply(idle());
        s = idle(); s.fault_clear = 1; apply(s);
        s = idle(); s.jump = 1; s.jump_target = 16'hC000; apply(s);
        s = idle(); s.dmem_access = 1; s.dmem_addr = 0; s.rf_a_sel = 0; apply(s);
        apply(idle());
        for (int i = 0; i < 260; i++) begin
            s = idle(); s.fault_clear = 1; apply(s);
            s = idle(); s.jump = 1; s.jump_target = 16'h8000 + i; apply(s);
            s = idle(); s.jump = 1; s.jump_target = 1 + i; apply(s);
        end
        s = idle(); s.fault_clear = 1; apply(s);
        s = idle(); s.fault_clear = 1; apply(s);
        apply(idle());
        s = idle(); s.jump = 1; s.jump_target = 16'hFFFF; apply(s);
        s = idle(); s.rf_we = 1; s.rf_wsel = 0; s.rf_b_sel = 0; apply(s);
        s = idle(); s.reset = 1; s.fault_clear = 1; apply(s);
        apply(idle());

        for (int i = 0; i < 3000; i++) begin
            s.reset       = ($urandom_range(0, 199) == 0);
            s.run_in      = ($urandom_range(0, 3) != 0);
            s.pc          = int'($urandom_range(0, 16'hFFFF));
            s.jump        = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 3));
            s.jump_target = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(0, 16'h7FFF)) :
                            (r == 2) ? int'($urandom_range(16'h8000, 16'hFFFF)) :
                            int'($urandom_range(0, 16'hFFFF));
            s.dmem_access = $urandom_range(0, 1) == 1;
            s.dmem_addr   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 16'hFFFF));
            s.rf_a_sel    = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 31));
            s.rf_b_sel    = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 31));
            s.rf_we       = $urandom_range(0, 1) == 1;
            s.rf_wsel     = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 31));
            s.syscall_req = $urandom_range(0, 1) == 1;
            s.fault_clear = ($urandom_range(0, 3) == 0);
            apply(s);
        end

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
